// File: rtl/axi_ar_arbiter_if.sv
// Read-address / read-data bundle between two AXI masters, the shared
// address channel toward the decoder, and the arbiter sitting in between.
// The "slave" modport is the arbiter's view (it serves the masters); the
// "master" modport is the view of whatever drives the masters and the
// downstream slave path around it.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

interface axi_ar_arbiter_if #(
    parameter int LEN_W = 4
);
    // Per-master read-address requests
    logic                      ARVALID_M0;
    logic                      ARVALID_M1;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M0;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M1;
    logic [LEN_W-1:0]          ARLEN_M0;
    logic [LEN_W-1:0]          ARLEN_M1;
    logic                      ARREADY_M0;
    logic                      ARREADY_M1;

    // Shared address channel toward the decoder
    logic                      ARVALID_S;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_S;
    logic [LEN_W-1:0]          ARLEN_S;
    logic                      ARID_S;
    logic                      ARREADY_S;

    // Shared read-data handshake from the slave path
    logic                      RVALID_S;
    logic                      RLAST_S;
    logic                      RREADY_S;

    // Per-master read-data handshake
    logic                      RVALID_M0;
    logic                      RVALID_M1;
    logic                      RREADY_M0;
    logic                      RREADY_M1;

    // Status
    logic                      GRANT_M0;
    logic                      GRANT_M1;
    logic                      LEN_ERR;

    modport slave (
        input  ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
        output ARREADY_M0, ARREADY_M1,
        output ARVALID_S, ARADDR_S, ARLEN_S, ARID_S,
        input  ARREADY_S,
        input  RVALID_S, RLAST_S,
        output RREADY_S,
        output RVALID_M0, RVALID_M1,
        input  RREADY_M0, RREADY_M1,
        output GRANT_M0, GRANT_M1, LEN_ERR
    );

    modport master (
        output ARVALID_M0, ARVALID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
        input  ARREADY_M0, ARREADY_M1,
        input  ARVALID_S, ARADDR_S, ARLEN_S, ARID_S,
        output ARREADY_S,
        output RVALID_S, RLAST_S,
        input  RREADY_S,
        input  RVALID_M0, RVALID_M1,
        output RREADY_M0, RREADY_M1,
        input  GRANT_M0, GRANT_M1, LEN_ERR
    );
endinterface

// File: rtl/axi_ar_arbiter.sv
// Two-master AXI read arbiter with at most one burst in flight.
// IDLE registers a winner, ADDR forwards the winner's address request,
// DATA routes read beats back to the winner until RLAST. A beat counter
// compared against the accepted ARLEN raises a one-cycle LEN_ERR pulse on
// a length mismatch without changing the flow.
//
// Build option: define AR_ARB_ROUND_ROBIN_EN to alternate between masters
// when both request together; without it M0 always wins ties.
// LEN_W on this module must match LEN_W of the connected interface.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

module axi_ar_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    axi_ar_arbiter_if.slave bus
);

    localparam int AW = `AXI_ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // State and registered burst context
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_win;        // 0 = M0 owns the channel, 1 = M1
    logic [LEN_W-1:0] r_len;        // ARLEN accepted for the current burst
    logic [LEN_W-1:0] r_cnt;        // beats seen so far in the current burst
    logic             r_len_err;
`ifdef AR_ARB_ROUND_ROBIN_EN
    logic             r_last;       // master that owned the previous burst
`endif

    // Combinational decode
    logic             w_req_any;
    logic             w_pick;
    logic             w_ar_hs;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_arvalid;
    logic [AW-1:0]    w_araddr;
    logic [LEN_W-1:0] w_arlen;
    logic             w_arid;
    logic             w_arready_m0;
    logic             w_arready_m1;
    logic             w_rready_s;
    logic             w_rvalid_m0;
    logic             w_rvalid_m1;

    // Beat counter increment that sticks at all-ones instead of wrapping,
    // so an overlong burst cannot alias back onto a short ARLEN.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        if (v == {LEN_W{1'b1}}) begin
            return v;
        end
        return v + LEN_W'(1);
    endfunction

    // A beat is wrong if RLAST comes early/late relative to the count of
    // beats already received, or if the expected final beat lacks RLAST.
    function automatic logic len_mismatch(input logic             last,
                                          input logic [LEN_W-1:0] cnt,
                                          input logic [LEN_W-1:0] len);
        return last ? (cnt != len) : (cnt == len);
    endfunction

    assign w_req_any = bus.ARVALID_M0 | bus.ARVALID_M1;

`ifdef AR_ARB_ROUND_ROBIN_EN
    // On a tie, serve the master that did not own the previous burst.
    assign w_pick = bus.ARVALID_M1 & (~bus.ARVALID_M0 | ~r_last);
`else
    // Fixed priority: M1 only wins when M0 is not asking.
    assign w_pick = ~bus.ARVALID_M0;
`endif

    // Next-state decode and per-state routing of both channels
    always_comb begin
        w_state_nxt  = r_state;
        w_arvalid    = 1'b0;
        w_araddr     = '0;
        w_arlen      = '0;
        w_arid       = 1'b0;
        w_arready_m0 = 1'b0;
        w_arready_m1 = 1'b0;
        w_rready_s   = 1'b0;
        w_rvalid_m0  = 1'b0;
        w_rvalid_m1  = 1'b0;
        w_ar_hs      = 1'b0;
        w_beat       = 1'b0;
        w_last_beat  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Winner is captured this cycle; the address goes out next cycle.
                if (w_req_any) begin
                    w_state_nxt = ST_ADDR;
                end
            end

            ST_ADDR: begin
                w_arid = r_win;
                if (r_win) begin
                    w_arvalid    = bus.ARVALID_M1;
                    w_araddr     = bus.ARADDR_M1;
                    w_arlen      = bus.ARLEN_M1;
                    w_arready_m1 = bus.ARREADY_S;
                end else begin
                    w_arvalid    = bus.ARVALID_M0;
                    w_araddr     = bus.ARADDR_M0;
                    w_arlen      = bus.ARLEN_M0;
                    w_arready_m0 = bus.ARREADY_S;
                end
                w_ar_hs = w_arvalid & bus.ARREADY_S;
                if (w_ar_hs) begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                if (r_win) begin
                    w_rready_s  = bus.RREADY_M1;
                    w_rvalid_m1 = bus.RVALID_S;
                end else begin
                    w_rready_s  = bus.RREADY_M0;
                    w_rvalid_m0 = bus.RVALID_S;
                end
                w_beat      = bus.RVALID_S & w_rready_s;
                w_last_beat = w_beat & bus.RLAST_S;
                // Always drop back to IDLE so a waiting master is arbitrated
                // fresh rather than chained onto this burst.
                if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any burst in flight
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the arbitration winner while idle
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_win <= 1'b0;
        end else if (r_state == ST_IDLE && w_req_any) begin
            r_win <= w_pick;
        end
    end

    // Latch burst length on address accept and count delivered beats
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_len <= '0;
            r_cnt <= '0;
        end else if (w_ar_hs) begin
            r_len <= w_arlen;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    // One-cycle length error pulse, evaluated on every delivered beat
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_beat & len_mismatch(bus.RLAST_S, r_cnt, r_len);
        end
    end

`ifdef AR_ARB_ROUND_ROBIN_EN
    // Remember who finished last; reset makes M0 the first preferred master
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last <= 1'b1;
        end else if (w_last_beat) begin
            r_last <= r_win;
        end
    end
`endif

    assign bus.ARVALID_S  = w_arvalid;
    assign bus.ARADDR_S   = w_araddr;
    assign bus.ARLEN_S    = w_arlen;
    assign bus.ARID_S     = w_arid;
    assign bus.ARREADY_M0 = w_arready_m0;
    assign bus.ARREADY_M1 = w_arready_m1;
    assign bus.RREADY_S   = w_rready_s;
    assign bus.RVALID_M0  = w_rvalid_m0;
    assign bus.RVALID_M1  = w_rvalid_m1;
    assign bus.GRANT_M0   = (r_state != ST_IDLE) & ~r_win;
    assign bus.GRANT_M1   = (r_state != ST_IDLE) &  r_win;
    assign bus.LEN_ERR    = r_len_err;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Scoreboard bench for axi_ar_arbiter: stimulus rounds push expected
// address grants and per-beat routing/LEN_ERR into queues; a negedge
// monitor pops and compares whenever the DUT shows a handshake.

`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

module tb_axi_ar_arbiter;

    localparam int LEN_W  = 4;
    localparam int AW     = `AXI_ADDR_BITS;
    localparam int BUDGET = 400;
    localparam int CNTMAX = (1 << LEN_W) - 1;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        int            len;
    } ar_t;

    typedef struct {
        int m;
        bit err;
    } beat_t;

    logic ACLK = 1'b0;
    logic ARESETn;

    axi_ar_arbiter_if #(.LEN_W(LEN_W)) bus ();

    axi_ar_arbiter #(.LEN_W(LEN_W)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int    total = 0;
    int    bad = 0;
    int    model_last = 1;   // previous owner as seen by the reference model
    bit    pend_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor: checks every handshake the DUT presents against the queues
    ar_t   mon_a;
    beat_t mon_b;
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            pend_err = 1'b0;
        end else begin
            chk("len_err", bus.LEN_ERR, pend_err);
            pend_err = 1'b0;
            chk("grant_onehot", bus.GRANT_M0 & bus.GRANT_M1, 0);
            if (!bus.GRANT_M0 && !bus.GRANT_M1)
                chk("idle_quiet", {bus.ARVALID_S, bus.RREADY_S, bus.RVALID_M0, bus.RVALID_M1}, 0);
            if (bus.ARVALID_S) begin
                if (exp_ar.size() == 0) begin
                    flag("ar_unexpected");
                end else begin
                    mon_a = exp_ar[0];
                    chk("arid", bus.ARID_S, mon_a.id);
                    chk("araddr", bus.ARADDR_S, mon_a.addr);
                    chk("arlen", bus.ARLEN_S, mon_a.len);
                    chk("ar_grant", mon_a.id != 0 ? bus.GRANT_M1 : bus.GRANT_M0, 1);
                    chk("arready_win", mon_a.id != 0 ? bus.ARREADY_M1 : bus.ARREADY_M0, bus.ARREADY_S);
                    chk("arready_lose", mon_a.id != 0 ? bus.ARREADY_M0 : bus.ARREADY_M1, 0);
                    if (bus.ARREADY_S) void'(exp_ar.pop_front());
                end
            end
            if (bus.RVALID_S && bus.RREADY_S) begin
                if (exp_beat.size() == 0) begin
                    flag("beat_unexpected");
                end else begin
                    mon_b = exp_beat.pop_front();
                    chk("r_win", mon_b.m != 0 ? bus.RVALID_M1 : bus.RVALID_M0, 1);
                    chk("r_lose", mon_b.m != 0 ? bus.RVALID_M0 : bus.RVALID_M1, 0);
                    chk("r_grant", mon_b.m != 0 ? bus.GRANT_M1 : bus.GRANT_M0, 1);
                    pend_err = mon_b.err;
                end
            end
        end
    end

    // Reference: push one burst's expected address and beats
    task automatic expect_burst(input int m, input logic [AW-1:0] addr, input int len, input int k);
        ar_t   a;
        beat_t b;
        int    cnt;
        a.id = m; a.addr = addr; a.len = len;
        exp_ar.push_back(a);
        for (int j = 1; j <= k; j++) begin
            cnt = (j - 1 > CNTMAX) ? CNTMAX : j - 1;
            b.m = m;
            b.err = (j == k) ? (cnt != len) : (cnt == len);
            exp_beat.push_back(b);
        end
    endtask

    // Master side: hold request until accepted
    task automatic drive_master(input int m);
        bit hs;
        int n;
        hs = 1'b0; n = 0;
        while (!hs && n <= BUDGET) begin
            @(negedge ACLK);
            hs = (m != 0) ? (bus.ARVALID_M1 && bus.ARREADY_M1) : (bus.ARVALID_M0 && bus.ARREADY_M0);
            @(posedge ACLK); #1;
            n++;
        end
        if (m != 0) bus.ARVALID_M1 = 1'b0; else bus.ARVALID_M0 = 1'b0;
        if (!hs) flag("ar_timeout");
    endtask

    // Slave side: accept nb addresses, then return k beats with RLAST at beat k
    task automatic drive_slave(input int nb, input int k0, input int k1, input int hold);
        bit hs, b, done;
        int n, waited, beat, k;
        for (int i = 0; i < nb; i++) begin
            k = (i == 0) ? k0 : k1;
            hs = 1'b0; n = 0; waited = 0;
            while (!hs && n <= BUDGET) begin
                bus.ARREADY_S = (waited < hold) ? 1'b0 : ((hold != 0) ? 1'b1 : ($urandom % 3 != 0));
                @(negedge ACLK);
                hs = bus.ARVALID_S && bus.ARREADY_S;
                if (bus.ARVALID_S) waited++;
                @(posedge ACLK); #1;
                n++;
            end
            bus.ARREADY_S = 1'b0;
            if (!hs) begin
                flag("slave_ar_timeout");
                return;
            end
            beat = 1; done = 1'b0; n = 0;
            while (!done && n <= BUDGET) begin
                bus.RVALID_S  = ($urandom % 4 != 0);
                bus.RLAST_S   = (beat == k);
                bus.RREADY_M0 = ($urandom % 4 != 0);
                bus.RREADY_M1 = ($urandom % 4 != 0);
                @(negedge ACLK);
                b = bus.RVALID_S && bus.RREADY_S;
                @(posedge ACLK); #1;
                n++;
                if (b) begin
                    if (beat == k) done = 1'b1;
                    beat++;
                end
            end
            bus.RVALID_S = 1'b0;
            bus.RLAST_S  = 1'b0;
            if (!done) begin
                flag("beat_timeout");
                return;
            end
        end
    endtask

    // One round: requests raised together from idle, served per arbitration rule
    task automatic run_round(input bit r0, input bit r1,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input int l0, input int l1, input int k0, input int k1,
                             input int hold);
        int first, nb;
        if (r0 && r1) begin
`ifdef AR_ARB_ROUND_ROBIN_EN
            first = (model_last == 0) ? 1 : 0;
`else
            first = 0;
`endif
            nb = 2;
        end else begin
            first = r1 ? 1 : 0;
            nb = 1;
        end
        expect_burst(first, first != 0 ? a1 : a0, first != 0 ? l1 : l0, first != 0 ? k1 : k0);
        if (nb == 2) expect_burst(1 - first, first != 0 ? a0 : a1, first != 0 ? l0 : l1, first != 0 ? k0 : k1);
        model_last = (nb == 2) ? 1 - first : first;

        bus.ARVALID_M0 = r0; bus.ARADDR_M0 = a0; bus.ARLEN_M0 = LEN_W'(l0);
        bus.ARVALID_M1 = r1; bus.ARADDR_M1 = a1; bus.ARLEN_M1 = LEN_W'(l1);
        fork
            begin if (r0) drive_master(0); end
            begin if (r1) drive_master(1); end
            drive_slave(nb, first != 0 ? k1 : k0, first != 0 ? k0 : k1, hold);
        join
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r, l0, l1, k0, k1, hold, n, nbeat;
        bit  hs;

        // Reset with busy-looking inputs: outputs must stay quiet
        ARESETn = 1'b0;
        bus.ARVALID_M0 = 1'b1; bus.ARVALID_M1 = 1'b1;
        bus.ARADDR_M0 = '0; bus.ARADDR_M1 = '0;
        bus.ARLEN_M0 = '0; bus.ARLEN_M1 = '0;
        bus.ARREADY_S = 1'b1; bus.RVALID_S = 1'b1; bus.RLAST_S = 1'b0;
        bus.RREADY_M0 = 1'b1; bus.RREADY_M1 = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_grant", {bus.GRANT_M0, bus.GRANT_M1}, 0);
        chk("rst_ar", {bus.ARVALID_S, bus.ARREADY_M0, bus.ARREADY_M1}, 0);
        chk("rst_r", {bus.RREADY_S, bus.RVALID_M0, bus.RVALID_M1}, 0);
        chk("rst_len_err", bus.LEN_ERR, 0);
        bus.ARVALID_M0 = 1'b0; bus.ARVALID_M1 = 1'b0;
        bus.ARREADY_S = 1'b0; bus.RVALID_S = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Single M0 burst of 4 beats at 0x1000
        run_round(1, 0, 32'h0000_1000, '0, 3, 0, 4, 0, 0);
        chk("grant_m0_dropped", bus.GRANT_M0, 0);

        // Simultaneous single-beat requests
        for (int i = 0; i < 4; i++)
            run_round(1, 1, 32'h100 + i, 32'h200 + i, 0, 0, 1, 1, 0);

        // Address held off for 5 cycles while the other master waits
        run_round(1, 1, 32'hABCD_0000, 32'h1234_5678, 2, 1, 3, 2, 5);

        // Early RLAST, then missing RLAST on the expected final beat
        run_round(1, 0, 32'h3000, '0, 3, 0, 2, 0, 0);
        chk("idle_after_early_last", bus.GRANT_M0, 0);
        run_round(0, 1, '0, 32'h4000, 0, 1, 0, 4, 0);
        chk("idle_after_late_last", bus.GRANT_M1, 0);

        // Randomized rounds
        for (int i = 0; i < 60; i++) begin
            r  = $urandom % 3;
            l0 = $urandom % 16;
            l1 = $urandom % 16;
            k0 = ($urandom % 5 == 0) ? 1 + $urandom % 16 : l0 + 1;
            k1 = ($urandom % 5 == 0) ? 1 + $urandom % 16 : l1 + 1;
            hold = ($urandom % 4 == 0) ? 1 + $urandom % 3 : 0;
            run_round(r != 1, r != 0, AW'($urandom), AW'($urandom), l0, l1, k0, k1, hold);
            repeat ($urandom % 3) @(posedge ACLK);
            #1;
        end

        // Reset after beat 2 of a 4-beat M0 burst
        @(posedge ACLK); #1;
        expect_burst(0, 32'h0000_A000, 3, 2);
        bus.ARADDR_M0 = 32'h0000_A000; bus.ARLEN_M0 = 4'd3; bus.ARVALID_M0 = 1'b1;
        bus.ARREADY_S = 1'b1; bus.RREADY_M0 = 1'b1; bus.RVALID_S = 1'b0;
        hs = 1'b0; n = 0;
        while (!hs && n < BUDGET) begin
            @(negedge ACLK);
            hs = bus.ARVALID_M0 && bus.ARREADY_M0;
            @(posedge ACLK); #1;
            n++;
        end
        if (!hs) flag("rst_test_ar");
        bus.ARVALID_M0 = 1'b0; bus.ARREADY_S = 1'b0;
        bus.RVALID_S = 1'b1; bus.RLAST_S = 1'b0;
        nbeat = 0; n = 0;
        while (nbeat < 2 && n < BUDGET) begin
            @(negedge ACLK);
            if (bus.RVALID_S && bus.RREADY_S) nbeat++;
            @(posedge ACLK); #1;
            n++;
        end
        if (nbeat < 2) flag("rst_test_beats");
        #2;
        ARESETn = 1'b0;
        #1;
        chk("async_rst_grant", {bus.GRANT_M0, bus.GRANT_M1}, 0);
        chk("async_rst_r", {bus.RREADY_S, bus.RVALID_M0}, 0);
        chk("async_rst_len_err", bus.LEN_ERR, 0);
        model_last = 1;
        repeat (2) @(posedge ACLK);
        #3;
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("post_rst_rready", bus.RREADY_S, 0);
        @(posedge ACLK); #1;
        bus.RVALID_S = 1'b0;
        run_round(1, 1, 32'h0000_B000, 32'h0000_C000, 1, 1, 2, 2, 0);

        repeat (3) @(posedge ACLK);
        #1;
        chk("ar_queue_empty", exp_ar.size(), 0);
        chk("beat_queue_empty", exp_beat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_ar_arbiter.md
AXI_AR_ARBITER -- requirements
Module: axi_ar_arbiter

Interface
REQ-001 Parameter: LEN_W, default 4, width of ARLEN and of the beat counter.
REQ-002 Port: ACLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: ARESETn  input  1  asynchronous, active-low reset.
REQ-004 Ports: ARVALID_M0/ARVALID_M1  input  1 each  master read-address requests.
REQ-005 Ports: ARADDR_M0/ARADDR_M1  input  `AXI_ADDR_BITS each  master read addresses.
REQ-006 Ports: ARLEN_M0/ARLEN_M1  input  LEN_W each  master burst lengths (beats-1).
REQ-007 Ports: ARREADY_M0/ARREADY_M1  output  1 each  address accept back to masters.
REQ-008 Ports: ARVALID_S output 1, ARADDR_S output `AXI_ADDR_BITS, ARLEN_S output LEN_W, ARID_S output 1 (winning master index)  shared address channel toward the address decoder.
REQ-009 Port: ARREADY_S  input  1  accept from the decoded slave path.
REQ-010 Ports: RVALID_S input 1, RLAST_S input 1, RREADY_S output 1  shared read-data handshake.
REQ-011 Ports: RVALID_M0/RVALID_M1 output 1, RREADY_M0/RREADY_M1 input 1  per-master read-data handshake.
REQ-012 Ports: GRANT_M0/GRANT_M1 output 1 (current owner, one-hot or zero); LEN_ERR output 1 (beat-count error pulse).

Function
REQ-013 The block SHALL implement FSM states IDLE, ADDR, DATA; at most one read burst outstanding.
REQ-014 IDLE: no grant, ARVALID_S=0, RREADY_S=0; if any ARVALID_Mx=1, winner SHALL be registered and state SHALL move to ADDR next cycle (1-cycle arbitration latency).
REQ-015 Both requesting in IDLE: winner SHALL be the master not served last; single requester always wins.
REQ-016 ADDR: ARVALID_S/ARADDR_S/ARLEN_S SHALL combinationally follow the winner's inputs, ARID_S=winner index, ARREADY_Mwin=ARREADY_S, loser's ARREADY=0.
REQ-017 Grant SHALL hold in ADDR until ARVALID_S&ARREADY_S; then ARLEN latched, beat counter cleared to 0, state to DATA.
REQ-018 DATA: RVALID_Mwin=RVALID_S, RREADY_S=RREADY_Mwin, loser's RVALID=0; ARVALID_S=0 and both ARREADY=0.
REQ-019 Each RVALID_S&RREADY_S beat SHALL increment counter (saturate at 2^LEN_W-1).
REQ-020 Beat with RLAST_S=1 SHALL end the burst: state to IDLE, last-served updated to winner, grant dropped next cycle.
REQ-021 LEN_ERR SHALL be a registered one-cycle pulse when an RLAST beat arrives with counter != latched length, or a non-RLAST beat arrives with counter == latched length; FSM behaviour unchanged by errors.
REQ-022 New request accepted in the cycle RLAST completes SHALL be arbitrated from IDLE on the following cycle (no back-to-back bypass).
REQ-023 GRANT_Mx SHALL be 1 exactly in ADDR and DATA for the winner.

Reset
REQ-024 ARESETn low SHALL immediately force IDLE, grants 0, counter 0, latched length 0, LEN_ERR 0, last-served=M1 (M0 preferred first), regardless of burst in progress.
REQ-025 Reset mid-burst SHALL drop the burst with no completion; remaining slave beats after reset release are not forwarded (RREADY_S=0 in IDLE).

Configuration
REQ-026 Macro AR_ARB_ROUND_ROBIN_EN defined: arbitration per REQ-015.
REQ-027 Macro undefined: fixed priority, M0 always wins simultaneous requests; last-served register absent; all other behaviour identical.

Verification
REQ-028 M0 alone, ARADDR_M0=32'h0000_1000, ARLEN=3, ARREADY_S=1, 4 beats, RLAST on 4th -> ARID_S=0, 4 beats to M0, GRANT_M0 falls after beat 4, LEN_ERR=0.
REQ-029 M0 and M1 request same cycle repeatedly, ARLEN=0 (with _EN) -> grants alternate M0,M1,M0,M1; without macro -> M0 every time while requesting.
REQ-030 ARREADY_S held low 5 cycles in ADDR with M1 requesting -> M0 grant held, ARREADY_M1=0, ARADDR_S stable until acceptance.
REQ-031 ARLEN=3, RLAST_S on 2nd beat -> LEN_ERR pulses 1 cycle, return to IDLE; ARLEN=1, no RLAST on 2nd beat -> LEN_ERR pulse, stay in DATA until RLAST.
REQ-032 ARESETn asserted after beat 2 of a 4-beat burst -> outputs at reset values asynchronously; after release, RREADY_S=0 and M0 re-arbitrated first.
